// File: rtl/sobel_pkg.sv
// Shared types and default geometry for the Sobel raster-scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sobel_pkg;

   // Default frame geometry (VGA).
   localparam int IMG_W_DEF = 640;
   localparam int IMG_H_DEF = 480;

   // Sequencer states. Explicit encodings keep the state register
   // readable in waveforms and stable across tool versions.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } scan_state_t;

endpackage

// File: rtl/scan_wrap_ctr.sv
// Up-counter with enable and synchronous clear that wraps to zero after MAX_P.
// Latency: count updates on the clock edge after en_i/clr_i; wrap_o is combinational from the count.
// Backpressure: none; the caller gates en_i.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clr_i          synchronous clear, dominates en_i
//   en_i           advance by one (wrapping at MAX_P)
//   cnt_o          current count
//   wrap_o         high while the count sits at MAX_P (terminal value)
module scan_wrap_ctr #(
   parameter int MAX_P = 639,
   parameter int W_P   = 10
) (
   input  logic           clk_i,
   input  logic           rst_i,
   input  logic           clr_i,
   input  logic           en_i,
   output logic [W_P-1:0] cnt_o,
   output logic           wrap_o
);

   localparam logic [W_P-1:0] MAX_C = W_P'(MAX_P);

   logic [W_P-1:0] cnt_q;
   logic [W_P-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         if (cnt_q == MAX_C) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + W_P'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign wrap_o = (cnt_q == MAX_C);

endmodule

// File: rtl/sobel_scan_ctrl.sv
// Raster-scan sequencer: tags each accepted pixel with column/row, frame/line markers and a 3x3-window-valid flag.
// Latency: a pixel accepted in cycle N is presented on valid_o in cycle N+1; done_o pulses one cycle after the eof pixel drains.
// Backpressure: ready_o = RUN && (!valid_o || ready_i); the output register holds all fields while ready_i is low.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   start_i, abort_i     begin a frame (IDLE only) / synchronous abort from any state
//   valid_i, ready_o     upstream pixel handshake
//   valid_o, ready_i     downstream tagged-pixel handshake
//   col_o, row_o         position of the tagged pixel
//   sof_o, eol_o, eof_o  first pixel, last column, last pixel of frame
//   win_valid_o          row>=2 and col>=2: a full 3x3 neighbourhood has been seen
//   busy_o, done_o       not IDLE / one-cycle frame-complete pulse
module sobel_scan_ctrl
   import sobel_pkg::*;
#(
   parameter int IMG_W_P = IMG_W_DEF,
   parameter int IMG_H_P = IMG_H_DEF,
   localparam int COL_W_P = $clog2(IMG_W_P),
   localparam int ROW_W_P = $clog2(IMG_H_P)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic               valid_i,
   output logic               ready_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic [COL_W_P-1:0] col_o,
   output logic [ROW_W_P-1:0] row_o,
   output logic               sof_o,
   output logic               eol_o,
   output logic               eof_o,
   output logic               win_valid_o,
   output logic               busy_o,
   output logic               done_o
);

   scan_state_t state_q, state_d;

   logic [COL_W_P-1:0] col_cnt;
   logic [ROW_W_P-1:0] row_cnt;
   logic               col_wrap;
   logic               row_wrap;
   logic               ctr_clr;
   logic               col_en;
   logic               row_en;

   logic               valid_q, valid_d;
   logic [COL_W_P-1:0] col_q,   col_d;
   logic [ROW_W_P-1:0] row_q,   row_d;
   logic               sof_q,   sof_d;
   logic               eol_q,   eol_d;
   logic               eof_q,   eof_d;
   logic               win_q,   win_d;
   logic               done_q,  done_d;

   logic               accept;
   logic               last_pix;
   logic               drain_ok;

   // Column counter wraps every line; its terminal flag steps the row.
   scan_wrap_ctr #(
      .MAX_P (IMG_W_P - 1),
      .W_P   (COL_W_P)
   ) u_col_ctr (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (ctr_clr),
      .en_i   (col_en),
      .cnt_o  (col_cnt),
      .wrap_o (col_wrap)
   );

   // Row counter never actually wraps: the last pixel clears both counters.
   // Its terminal flag is used to recognise the last line.
   scan_wrap_ctr #(
      .MAX_P (IMG_H_P - 1),
      .W_P   (ROW_W_P)
   ) u_row_ctr (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (ctr_clr),
      .en_i   (row_en),
      .cnt_o  (row_cnt),
      .wrap_o (row_wrap)
   );

   // Skid-free single output register: we may accept whenever the slot is
   // empty or is being emptied this cycle.
   assign ready_o  = (state_q == ST_RUN) && (!valid_q || ready_i);
   assign accept   = valid_i && ready_o;
   assign last_pix = col_wrap && row_wrap;
   // The eof pixel has left (or is leaving) the output register.
   assign drain_ok = !valid_q || ready_i;

   assign col_en = accept;
   assign row_en = accept && col_wrap;

   always_comb begin
      state_d = state_q;
      ctr_clr = 1'b0;
      done_d  = 1'b0;
      valid_d = valid_q;
      col_d   = col_q;
      row_d   = row_q;
      sof_d   = sof_q;
      eol_d   = eol_q;
      eof_d   = eof_q;
      win_d   = win_q;

      if (abort_i) begin
         // Abort dominates start and any in-flight handshake; the tag fields
         // are left as-is since valid_o is dropped.
         state_d = ST_IDLE;
         ctr_clr = 1'b1;
         valid_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  state_d = ST_RUN;
                  ctr_clr = 1'b1;
               end
            end
            ST_RUN: begin
               if (accept && last_pix) begin
                  state_d = ST_DONE;
                  ctr_clr = 1'b1;
               end
            end
            ST_DONE: begin
               if (drain_ok) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase

         if (accept) begin
            // Flags are taken from the counters before they advance.
            valid_d = 1'b1;
            col_d   = col_cnt;
            row_d   = row_cnt;
            sof_d   = (col_cnt == '0) && (row_cnt == '0);
            eol_d   = col_wrap;
            eof_d   = last_pix;
            win_d   = (col_cnt >= COL_W_P'(2)) && (row_cnt >= ROW_W_P'(2));
         end else if (ready_i) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         valid_q <= 1'b0;
         col_q   <= '0;
         row_q   <= '0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         eof_q   <= 1'b0;
         win_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         col_q   <= col_d;
         row_q   <= row_d;
         sof_q   <= sof_d;
         eol_q   <= eol_d;
         eof_q   <= eof_d;
         win_q   <= win_d;
         done_q  <= done_d;
      end
   end

   assign valid_o     = valid_q;
   assign col_o       = col_q;
   assign row_o       = row_q;
   assign sof_o       = sof_q;
   assign eol_o       = eol_q;
   assign eof_o       = eof_q;
   assign win_valid_o = win_q;
   assign busy_o      = (state_q != ST_IDLE);
   assign done_o      = done_q;

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// Self-checking bench for sobel_scan_ctrl on a 4x3 frame.
// A pixel-index model predicts every output each cycle; a few literal expectations pin the model.
// Directed phases cover stall, gaps, abort, async reset, back-to-back frames; a random phase follows.
module tb_sobel_scan_ctrl;

   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic       clk = 1'b0;
   logic       rst_i, start_i, abort_i, valid_i, ready_i;
   logic       ready_o, valid_o, sof_o, eol_o, eof_o, win_valid_o, busy_o, done_o;
   logic [1:0] col_o;
   logic [1:0] row_o;

   always #5 clk = ~clk;

   sobel_scan_ctrl #(.IMG_W_P(W), .IMG_H_P(H)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
      .valid_i(valid_i), .ready_o(ready_o), .valid_o(valid_o), .ready_i(ready_i),
      .col_o(col_o), .row_o(row_o), .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o),
      .win_valid_o(win_valid_o), .busy_o(busy_o), .done_o(done_o)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Model: frame mode (0 idle, 1 scanning, 2 waiting for eof to drain),
   // index of next pixel to accept, and the pixel index held at the output.
   int m_st, m_idx, m_oidx;
   bit m_ov, m_done;

   int cyc, base;
   int hs_cnt, win_cnt, eof_cyc, sof_cyc, done_cyc, sof_gap;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_idx = 0; m_oidx = 0; m_ov = 0; m_done = 0;
   endtask

   task automatic clr_tally();
      base = cyc; hs_cnt = 0; win_cnt = 0;
      eof_cyc = -1; sof_cyc = -1; done_cyc = -1; sof_gap = -1;
   endtask

   task automatic compare();
      bit m_rdy;
      int c, r;
      m_rdy = (m_st == 1) && (!m_ov || ready_i);
      chk("ready_o", ready_o, m_rdy);
      chk("valid_o", valid_o, m_ov);
      chk("busy_o", busy_o, m_st != 0);
      chk("done_o", done_o, m_done);
      if (m_ov) begin
         c = m_oidx % W;
         r = m_oidx / W;
         chk("col_o", col_o, c);
         chk("row_o", row_o, r);
         chk("sof_o", sof_o, m_oidx == 0);
         chk("eol_o", eol_o, c == W - 1);
         chk("eof_o", eof_o, m_oidx == N - 1);
         chk("win_valid_o", win_valid_o, (c >= 2) && (r >= 2));
      end
      if (valid_o && ready_i) begin
         hs_cnt++;
         if (win_valid_o) win_cnt++;
         if (eof_o) eof_cyc = cyc - base;
      end
      if (valid_o && sof_o && sof_cyc < 0) sof_cyc = cyc - base;
      if (valid_o && sof_o && done_cyc >= 0 && sof_gap < 0) sof_gap = (cyc - base) - done_cyc;
      if (done_o) done_cyc = cyc - base;
   endtask

   task automatic update();
      int  st;
      bit  ov, rdy, acc, drain;
      st    = m_st;
      ov    = m_ov;
      rdy   = (st == 1) && (!ov || ready_i);
      acc   = valid_i && rdy;
      drain = (st == 2) && (!ov || ready_i);
      if (abort_i) begin
         m_st = 0; m_ov = 0; m_idx = 0; m_done = 0;
      end else begin
         m_done = drain;
         if (acc) begin
            m_ov   = 1;
            m_oidx = m_idx;
            if (m_idx == N - 1) begin
               m_idx = 0;
               m_st  = 2;
            end else begin
               m_idx++;
            end
         end else if (ready_i) begin
            m_ov = 0;
         end
         if (st == 0 && start_i) begin
            m_st  = 1;
            m_idx = 0;
         end
         if (drain) m_st = 0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      #2;
      compare();
      @(posedge clk);
      update();
      #1;
      cyc++;
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, " flags"}, {valid_o, sof_o, eol_o, eof_o, win_valid_o, busy_o, done_o, ready_o}, 0);
      chk({nm, " col"}, col_o, 0);
      chk({nm, " row"}, row_o, 0);
   endtask

   task automatic start_frame();
      start_i = 1; step(); start_i = 0;
   endtask

   initial begin
      int stall;
      bit aborted;
      rst_i = 1; start_i = 0; abort_i = 0; valid_i = 0; ready_i = 0;
      cyc = 0;
      model_reset();
      clr_tally();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      rst_i = 0;
      repeat (2) step();

      // A: full-rate frame
      clr_tally();
      valid_i = 1; ready_i = 1;
      start_frame();
      repeat (20) step();
      chk("A handshakes", hs_cnt, 12);
      chk("A win count", win_cnt, 2);
      chk("A sof cycle", sof_cyc, 2);
      chk("A eof cycle", eof_cyc, 13);
      chk("A done cycle", done_cyc, 14);

      // B: downstream stall of 5 cycles while pixel (1,1) is presented
      clr_tally();
      start_frame();
      stall = 0;
      repeat (30) begin
         ready_i = !(m_ov && m_oidx == 5 && stall < 5);
         if (!ready_i) stall++;
         step();
      end
      ready_i = 1;
      chk("B stall cycles", stall, 5);
      chk("B handshakes", hs_cnt, 12);
      chk("B done cycle", done_cyc, 19);

      // C: source valid every other cycle
      clr_tally();
      valid_i = 0;
      start_frame();
      for (int k = 0; k < 40; k++) begin
         valid_i = k[0];
         step();
      end
      chk("C handshakes", hs_cnt, 12);

      // D: abort while (2,1) is presented, then start+abort together, then clean frame
      clr_tally();
      valid_i = 1;
      start_frame();
      aborted = 0;
      for (int k = 0; k < 12 && !aborted; k++) begin
         abort_i = m_ov && m_oidx == 6;
         aborted = abort_i;
         step();
      end
      abort_i = 0;
      chk("D abort seen", aborted, 1);
      chk("D abort busy", busy_o, 0);
      chk("D abort valid", valid_o, 0);
      start_i = 1; abort_i = 1;
      step();
      start_i = 0; abort_i = 0;
      chk("D start+abort busy", busy_o, 0);
      repeat (4) step();
      chk("D no done", done_cyc, -1);
      clr_tally();
      start_frame();
      repeat (20) step();
      chk("D restart sof cycle", sof_cyc, 2);
      chk("D restart handshakes", hs_cnt, 12);

      // E: asynchronous reset between clock edges mid-frame
      start_frame();
      repeat (5) step();
      @(negedge clk);
      #3 rst_i = 1;
      #1 chk_reset_vals("async reset");
      model_reset();
      @(posedge clk);
      #1 rst_i = 0;
      clr_tally();
      start_frame();
      repeat (20) step();
      chk("E handshakes", hs_cnt, 12);

      // F: start held high, back-to-back frames
      clr_tally();
      start_i = 1;
      repeat (32) step();
      start_i = 0;
      chk("F sof gap", sof_gap, 2);
      chk("F handshakes", hs_cnt, 26);
      repeat (20) step();

      // G: random traffic
      for (int k = 0; k < 4000; k++) begin
         start_i = ($urandom % 4) == 0;
         valid_i = ($urandom % 3) != 0;
         ready_i = ($urandom % 4) != 0;
         abort_i = ($urandom % 97) == 0;
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
